// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: PC feedback, imem request/response channel and decode-side buffer head.
interface instr_fetch_unit_if #(
  parameter int unsigned size = 32
);
  logic [size-1:0] pc;
  logic            branch;
  logic [size-1:0] pc_4;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [size-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [size-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [size-1:0] id_instr;
  logic [size-1:0] id_pc;

  // Fetch-unit view
  modport master (
    input  pc, branch, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output pc_4, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
  );

  // Environment view (PC register, instruction memory, decode)
  modport slave (
    output pc, branch, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  pc_4, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues credit-limited imem requests for the current pc,
// pairs in-order responses with their request pc and buffers them for decode.
// A taken branch flushes the buffer and discards responses still in flight.
module instr_fetch_unit #(
  parameter int unsigned size      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [size-1:0]    buf_pc_q    [BUF_DEPTH];
  logic [size-1:0]    buf_instr_q [BUF_DEPTH];
  logic [size-1:0]    tag_pc_q    [BUF_DEPTH];

  logic [SUM_W-1:0]   inflight;
  logic               req_valid;
  logic               accept;
  logic               rsp_ok;
  logic               stale;
  logic               push;
  logic               pop;
  logic               head_valid;

  assign inflight   = SUM_W'(out_q) + SUM_W'(occ_q);
  assign head_valid = (occ_q != '0);

  // Handshake qualification; responses with nothing outstanding are ignored
  always_comb begin
    req_valid = (state_q == S_RUN) && !bus.branch && (inflight < SUM_W'(BUF_DEPTH));
    accept    = req_valid && bus.imem_req_ready;
    rsp_ok    = bus.imem_rsp_valid && (out_q != '0);
    stale     = bus.branch || (state_q == S_DRAIN);
    push      = rsp_ok && !stale;
    pop       = head_valid && bus.id_ready;
  end

  // State, counters and queue pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Next-state: FSM, outstanding/occupancy bookkeeping and branch flush
  always_comb begin
    state_d  = state_q;
    out_d    = out_q + CNT_W'(accept) - CNT_W'(rsp_ok);
    occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
    drop_d   = drop_q;
    rd_d     = pop  ? rd_q + PTR_W'(1) : rd_q;
    wr_d     = push ? wr_q + PTR_W'(1) : wr_q;
    tag_rd_d = push   ? tag_rd_q + PTR_W'(1) : tag_rd_q;
    tag_wr_d = accept ? tag_wr_q + PTR_W'(1) : tag_wr_q;

    if (bus.branch) begin
      occ_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
    end

    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (bus.branch && (out_d != '0)) begin
          state_d = S_DRAIN;
          drop_d  = out_d;
        end
      end
      S_DRAIN: begin
        if (rsp_ok) begin
          drop_d = drop_q - CNT_W'(1);
          if (drop_q == CNT_W'(1)) state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag queue and fetch buffer storage (contents qualified by pointers/occupancy)
  always_ff @(posedge clk) begin
    if (accept) tag_pc_q[tag_wr_q] <= bus.pc;
    if (push) begin
      buf_pc_q[wr_q]    <= tag_pc_q[tag_rd_q];
      buf_instr_q[wr_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = {bus.pc[size-1:2], 2'b00};
  assign bus.pc_4           = accept ? bus.pc + size'(4) : bus.pc;
  assign bus.id_valid       = head_valid;
  assign bus.id_pc          = head_valid ? buf_pc_q[rd_q]    : '0;
  assign bus.id_instr       = head_valid ? buf_instr_q[rd_q] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC-register model and a latency-1 imem model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  logic mem_en;
  logic [31:0] pc_seed;
  logic [31:0] br_target;
  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit_if #(.size(32)) ifc ();

  instr_fetch_unit #(.size(32), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hBEEF, a[15:0]};
  endfunction

  // Snapshot of the environment-visible handshakes, taken mid-cycle
  logic        acc_s, rsp_s, br_s;
  logic [31:0] addr_s, pc4_s;
  always @(negedge clk) begin
    acc_s  = ifc.imem_req_valid && ifc.imem_req_ready;
    addr_s = ifc.imem_addr;
    rsp_s  = ifc.imem_rsp_valid;
    pc4_s  = ifc.pc_4;
    br_s   = ifc.branch;
  end

  // PC register and in-order imem with one-cycle response latency
  logic [31:0] memq[$];
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      memq.delete();
      ifc.pc = pc_seed;
    end else begin
      if (rsp_s && memq.size() > 0) void'(memq.pop_front());
      if (acc_s) memq.push_back(addr_s);
      ifc.pc = br_s ? br_target : pc4_s;
    end
    ifc.imem_rsp_valid = mem_en && reset && (memq.size() > 0);
    ifc.imem_rsp_data  = (memq.size() > 0) ? instr_of(memq[0]) : 32'h0;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset              = 1'b0;
    ifc.branch         = 1'b0;
    ifc.imem_req_ready = 1'($urandom);
    ifc.id_ready       = 1'($urandom);
    mem_en             = 1'b0;
    pc_seed            = $urandom;
    br_target          = 32'h0;

    // Reset with arbitrary inputs
    cyc(); #1;
    chk("rst_rv",    32'(ifc.imem_req_valid), 32'd0);
    chk("rst_idv",   32'(ifc.id_valid), 32'd0);
    chk("rst_idpc",  ifc.id_pc, 32'h0);
    chk("rst_instr", ifc.id_instr, 32'h0);
    chk("rst_pc4",   ifc.pc_4, pc_seed);
    cyc(); ifc.imem_req_ready = 1'b1; ifc.id_ready = 1'($urandom); #1;
    chk("rst_rv2",   32'(ifc.imem_req_valid), 32'd0);
    chk("rst_pc4b",  ifc.pc_4, pc_seed);
    pc_seed = 32'h0; ifc.id_ready = 1'b1; mem_en = 1'b1;
    cyc(); reset = 1'b1; #1;
    chk("idle_rv",   32'(ifc.imem_req_valid), 32'd0);
    chk("idle_pc4",  ifc.pc_4, 32'h0);

    // Streaming
    cyc(); #1;
    chk("s1_rv", 32'(ifc.imem_req_valid), 32'd1); chk("s1_addr", ifc.imem_addr, 32'h0);
    chk("s1_pc4", ifc.pc_4, 32'h4); chk("s1_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("s2_rv", 32'(ifc.imem_req_valid), 32'd1); chk("s2_addr", ifc.imem_addr, 32'h4);
    chk("s2_pc4", ifc.pc_4, 32'h8); chk("s2_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("s3_rv", 32'(ifc.imem_req_valid), 32'd0); chk("s3_pc4", ifc.pc_4, 32'h8);
    chk("s3_idv", 32'(ifc.id_valid), 32'd1); chk("s3_idpc", ifc.id_pc, 32'h0);
    chk("s3_instr", ifc.id_instr, instr_of(32'h0));
    cyc(); #1;
    chk("s4_rv", 32'(ifc.imem_req_valid), 32'd1); chk("s4_addr", ifc.imem_addr, 32'h8);
    chk("s4_idv", 32'(ifc.id_valid), 32'd1); chk("s4_idpc", ifc.id_pc, 32'h4);
    cyc(); #1;
    chk("s5_rv", 32'(ifc.imem_req_valid), 32'd1); chk("s5_addr", ifc.imem_addr, 32'hC);
    chk("s5_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("s6_rv", 32'(ifc.imem_req_valid), 32'd0); chk("s6_idv", 32'(ifc.id_valid), 32'd1);
    chk("s6_idpc", ifc.id_pc, 32'h8);

    // Backpressure from decode
    cyc(); ifc.id_ready = 1'b0; #1;
    chk("b1_rv", 32'(ifc.imem_req_valid), 32'd1); chk("b1_addr", ifc.imem_addr, 32'h10);
    chk("b1_pc4", ifc.pc_4, 32'h14); chk("b1_idpc", ifc.id_pc, 32'hC);
    cyc(); #1;
    chk("b2_rv", 32'(ifc.imem_req_valid), 32'd0); chk("b2_pc4", ifc.pc_4, 32'h14);
    cyc(); #1;
    chk("b3_rv", 32'(ifc.imem_req_valid), 32'd0); chk("b3_pc4", ifc.pc_4, 32'h14);
    chk("b3_idpc", ifc.id_pc, 32'hC);
    cyc(); #1;
    chk("b4_rv", 32'(ifc.imem_req_valid), 32'd0); chk("b4_idpc", ifc.id_pc, 32'hC);
    cyc(); ifc.id_ready = 1'b1; #1;
    chk("b5_rv", 32'(ifc.imem_req_valid), 32'd0); chk("b5_idv", 32'(ifc.id_valid), 32'd1);
    chk("b5_idpc", ifc.id_pc, 32'hC);
    cyc(); #1;
    chk("b6_rv", 32'(ifc.imem_req_valid), 32'd1); chk("b6_addr", ifc.imem_addr, 32'h14);
    chk("b6_idpc", ifc.id_pc, 32'h10); chk("b6_instr", ifc.id_instr, instr_of(32'h10));
    mem_en = 1'b0;

    // Branch flush with two requests outstanding
    cyc(); #1;
    chk("f1_rv", 32'(ifc.imem_req_valid), 32'd1); chk("f1_addr", ifc.imem_addr, 32'h18);
    chk("f1_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); ifc.branch = 1'b1; br_target = 32'h100; #1;
    chk("f2_rv", 32'(ifc.imem_req_valid), 32'd0); chk("f2_pc4", ifc.pc_4, 32'h1C);
    cyc(); ifc.branch = 1'b0; mem_en = 1'b1; #1;
    chk("f3_rv", 32'(ifc.imem_req_valid), 32'd0); chk("f3_pc4", ifc.pc_4, 32'h100);
    chk("f3_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("f4_rv", 32'(ifc.imem_req_valid), 32'd0); chk("f4_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("f5_rv", 32'(ifc.imem_req_valid), 32'd0); chk("f5_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("f6_rv", 32'(ifc.imem_req_valid), 32'd1); chk("f6_addr", ifc.imem_addr, 32'h100);
    chk("f6_pc4", ifc.pc_4, 32'h104); chk("f6_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("f7_addr", ifc.imem_addr, 32'h104); chk("f7_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("f8_idv", 32'(ifc.id_valid), 32'd1); chk("f8_idpc", ifc.id_pc, 32'h100);
    chk("f8_instr", ifc.id_instr, instr_of(32'h100));

    // Branch coinciding with an id handshake and a response
    cyc(); #1;
    chk("c1_addr", ifc.imem_addr, 32'h108); chk("c1_idpc", ifc.id_pc, 32'h104);
    cyc(); #1;
    chk("c2_rv", 32'(ifc.imem_req_valid), 32'd1); chk("c2_addr", ifc.imem_addr, 32'h10C);
    cyc(); ifc.branch = 1'b1; br_target = 32'h200; #1;
    chk("c3_rv", 32'(ifc.imem_req_valid), 32'd0); chk("c3_idv", 32'(ifc.id_valid), 32'd1);
    chk("c3_idpc", ifc.id_pc, 32'h108); chk("c3_instr", ifc.id_instr, instr_of(32'h108));
    chk("c3_rsp", 32'(ifc.imem_rsp_valid), 32'd1);
    cyc(); ifc.branch = 1'b0; #1;
    chk("c4_idv", 32'(ifc.id_valid), 32'd0); chk("c4_rv", 32'(ifc.imem_req_valid), 32'd1);
    chk("c4_addr", ifc.imem_addr, 32'h200);
    cyc(); #1;
    chk("c5_addr", ifc.imem_addr, 32'h204); chk("c5_idv", 32'(ifc.id_valid), 32'd0);

    // Address wrap, then async reset while draining
    cyc(); ifc.branch = 1'b1; br_target = 32'hFFFF_FFFC; #1;
    chk("w1_idpc", ifc.id_pc, 32'h200); chk("w1_rv", 32'(ifc.imem_req_valid), 32'd0);
    cyc(); ifc.branch = 1'b0; mem_en = 1'b0; #1;
    chk("w2_addr", ifc.imem_addr, 32'hFFFF_FFFC); chk("w2_pc4", ifc.pc_4, 32'h0);
    chk("w2_idv", 32'(ifc.id_valid), 32'd0);
    cyc(); #1;
    chk("w3_addr", ifc.imem_addr, 32'h0); chk("w3_pc4", ifc.pc_4, 32'h4);
    cyc(); ifc.branch = 1'b1; br_target = 32'h300; #1;
    chk("w4_rv", 32'(ifc.imem_req_valid), 32'd0);
    cyc(); ifc.branch = 1'b0; #1;
    chk("w5_rv", 32'(ifc.imem_req_valid), 32'd0); chk("w5_pc4", ifc.pc_4, 32'h300);
    reset = 1'b0; #1;
    chk("ar_rv", 32'(ifc.imem_req_valid), 32'd0); chk("ar_idv", 32'(ifc.id_valid), 32'd0);
    chk("ar_idpc", ifc.id_pc, 32'h0); chk("ar_pc4", ifc.pc_4, 32'h300);
    pc_seed = 32'h400; mem_en = 1'b1;
    cyc(); reset = 1'b1; #1;
    chk("ar_idle", 32'(ifc.imem_req_valid), 32'd0);
    cyc(); #1;
    chk("ar_run", 32'(ifc.imem_req_valid), 32'd1); chk("ar_addr", ifc.imem_addr, 32'h400);
    cyc(); #1;
    chk("ar_run2", 32'(ifc.imem_req_valid), 32'd1); chk("ar_addr2", ifc.imem_addr, 32'h404);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
